// File: rtl/serial_adder_pkg.sv
//------------------------------------------------------------------------------
// Module   : serial_adder_pkg
// Brief    : Shared types and constants for the bit-serial adder.
//            State encoding and the reset value of the result register.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package serial_adder_pkg;

    // FSM state encoding
    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SHIFT = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

    // Every bit of the result/sum registers resets to this value
    localparam logic C_RESULT_RST_BIT = 1'b0;

endpackage : serial_adder_pkg

`default_nettype wire

// File: rtl/serial_adder_full_adder.sv
//------------------------------------------------------------------------------
// Module   : half_adder, full_adder
// Brief    : Combinational adder cells used by serial_adder.
//            full_adder = two half_adder cells plus an OR on the carries.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module half_adder (
    input  logic i_a,
    input  logic i_b,
    output logic o_sum,
    output logic o_carry
);

    assign o_sum   = i_a ^ i_b;
    assign o_carry = i_a & i_b;

endmodule : half_adder

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic w_s0;
    logic w_c0;
    logic w_c1;

    // First cell adds the operand bits
    half_adder u_ha0 (
        .i_a     (a),
        .i_b     (b),
        .o_sum   (w_s0),
        .o_carry (w_c0)
    );

    // Second cell folds in the incoming carry
    half_adder u_ha1 (
        .i_a     (w_s0),
        .i_b     (cin),
        .o_sum   (sum),
        .o_carry (w_c1)
    );

    // At most one of the two cells can generate a carry, so OR is exact
    assign cout = w_c0 | w_c1;

endmodule : full_adder

`default_nettype wire

// File: rtl/serial_adder.sv
//------------------------------------------------------------------------------
// Module   : serial_adder
// Brief    : Bit-serial WIDTH-bit adder, LSB first, one bit per clock.
//            Operands load on an accepted start, the result and final carry
//            are presented with a one-cycle done pulse.
//            Optional macro SERIAL_ADDER_SUB_EN adds a 'sub' input that turns
//            the operation into a - b (carry_out = 1 means no borrow).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry_out;

    logic             w_bit_sum;
    logic             w_bit_carry;
    logic [WIDTH-1:0] w_result_next;
    logic [WIDTH-1:0] w_load_b;
    logic             w_load_carry;
    logic             w_last_bit;

    // Subtraction is a + ~b + 1: invert b and seed the carry with 1
`ifdef SERIAL_ADDER_SUB_EN
    assign w_load_b     = sub ? ~b : b;
    assign w_load_carry = sub;
`else
    assign w_load_b     = b;
    assign w_load_carry = 1'b0;
`endif

    // Single full-adder cell consumes the current LSBs and the carry flop
    full_adder u_fa (
        .a    (r_a_sh[0]),
        .b    (r_b_sh[0]),
        .cin  (r_carry),
        .sum  (w_bit_sum),
        .cout (w_bit_carry)
    );

    assign w_result_next = {w_bit_sum, r_result[WIDTH-1:1]};
    assign w_last_bit    = (r_count == CNT_W'(WIDTH - 1));

    // FSM, shift registers, counter, carry flop and held outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_a_sh      <= '0;
            r_b_sh      <= '0;
            r_result    <= {WIDTH{C_RESULT_RST_BIT}};
            r_carry     <= 1'b0;
            r_count     <= '0;
            r_sum       <= {WIDTH{C_RESULT_RST_BIT}};
            r_carry_out <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a_sh  <= a;
                        r_b_sh  <= w_load_b;
                        r_carry <= w_load_carry;
                        r_count <= '0;
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
                    r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
                    r_result <= w_result_next;
                    r_carry  <= w_bit_carry;
                    r_count  <= r_count + CNT_W'(1);
                    if (w_last_bit) begin
                        // Outputs update only here, so they stay put in IDLE
                        r_sum       <= w_result_next;
                        r_carry_out <= w_bit_carry;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = (r_state == ST_SHIFT);
    assign done      = (r_state == ST_DONE);
    assign sum       = r_sum;
    assign carry_out = r_carry_out;

endmodule : serial_adder

`default_nettype wire

// File: tb/tb_serial_adder.sv
//------------------------------------------------------------------------------
// Module   : tb_serial_adder
// Brief    : Directed self-checking bench for serial_adder (WIDTH = 8).
//            Define SERIAL_ADDER_SUB_EN to also exercise subtraction.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             sub = 1'b0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
`ifdef SERIAL_ADDER_SUB_EN
        .sub       (sub),
`endif
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .carry_out (carry_out)
    );

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (sum !== 8'h00) begin errors++; $display("FAIL reset_sum got %h want 00", sum); end
        checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL reset_cout got %b want 0", carry_out); end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
    endtask

    // 0+0: busy for exactly 8 cycles after the start edge, done after edge E+8
    task automatic test_latency;
        @(negedge clk); a = 8'h00; b = 8'h00; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL lat_busy[%0d] got %b want 1", k, busy); end
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL lat_done_early[%0d] got %b want 0", k, done); end
            @(posedge clk); #1;
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL lat_done got %b want 1", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL lat_busy_end got %b want 0", busy); end
        checks++; if (sum !== 8'h00) begin errors++; $display("FAIL lat_sum got %h want 00", sum); end
        checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL lat_cout got %b want 0", carry_out); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL lat_done_pulse got %b want 0", done); end
    endtask

    task automatic test_add_vectors;
        logic [7:0] va [4] = '{8'hFF, 8'h5A, 8'h80, 8'hFF};
        logic [7:0] vb [4] = '{8'h01, 8'h3C, 8'h80, 8'hFF};
        logic [7:0] vs [4] = '{8'h00, 8'h96, 8'h00, 8'hFE};
        logic       vc [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        int n;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); a = va[i]; b = vb[i]; start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
            a = 8'h00; b = 8'h00;   // operands may change after load
            n = 0;
            while (done !== 1'b1 && n < 12) begin @(posedge clk); #1; n++; end
            checks++; if (n != 8) begin errors++; $display("FAIL add_lat[%0d] got %0d want 8", i, n); end
            checks++; if (sum !== vs[i]) begin errors++; $display("FAIL add_sum[%0d] got %h want %h", i, sum, vs[i]); end
            checks++; if (carry_out !== vc[i]) begin errors++; $display("FAIL add_cout[%0d] got %b want %b", i, carry_out, vc[i]); end
            @(posedge clk); #1;
            checks++; if (sum !== vs[i]) begin errors++; $display("FAIL add_hold[%0d] got %h want %h", i, sum, vs[i]); end
        end
    endtask

    // Second start at busy cycle 3 must not disturb the op in flight
    task automatic test_ignore_start;
        int n;
        @(negedge clk); a = 8'h0F; b = 8'h01; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        a = 8'hFF; b = 8'hFF; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n = 3;
        while (done !== 1'b1 && n < 15) begin @(posedge clk); #1; n++; end
        checks++; if (n != 8) begin errors++; $display("FAIL ign_lat got %0d want 8", n); end
        checks++; if (sum !== 8'h10) begin errors++; $display("FAIL ign_sum got %h want 10", sum); end
        checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL ign_cout got %b want 0", carry_out); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_restart got %b want 0", busy); end
    endtask

    task automatic test_reset_mid;
        int n;
        logic seen;
        @(negedge clk); a = 8'hAA; b = 8'h55; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b want 0", busy); end
        checks++; if (sum !== 8'h00) begin errors++; $display("FAIL rst_mid_sum got %h want 00", sum); end
        checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL rst_mid_cout got %b want 0", carry_out); end
        @(negedge clk); rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_mid_activity got %b want 0", seen); end
        @(negedge clk); a = 8'h12; b = 8'h34; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 12) begin @(posedge clk); #1; n++; end
        checks++; if (n != 8) begin errors++; $display("FAIL rst_new_lat got %0d want 8", n); end
        checks++; if (sum !== 8'h46) begin errors++; $display("FAIL rst_new_sum got %h want 46", sum); end
        checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL rst_new_cout got %b want 0", carry_out); end
        @(posedge clk); #1;
    endtask

    // Start held high: done at edges E+8, E+18, E+28
    task automatic test_back_to_back;
        logic exp_done;
        @(negedge clk); a = 8'h01; b = 8'h02; start = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k <= 29; k++) begin
            @(posedge clk); #1;
            exp_done = ((k % 10) == 8);
            checks++; if (done !== exp_done) begin errors++; $display("FAIL b2b_done[%0d] got %b want %b", k, done, exp_done); end
            if (k >= 8) begin
                checks++; if (sum !== 8'h03) begin errors++; $display("FAIL b2b_sum[%0d] got %h want 03", k, sum); end
            end
        end
        start = 1'b0;
        @(posedge clk); #1;
    endtask

`ifdef SERIAL_ADDER_SUB_EN
    task automatic test_sub;
        logic [7:0] va [2] = '{8'h10, 8'h01};
        logic [7:0] vb [2] = '{8'h01, 8'h02};
        logic [7:0] vs [2] = '{8'h0F, 8'hFF};
        logic       vc [2] = '{1'b1, 1'b0};
        int n;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); a = va[i]; b = vb[i]; sub = 1'b1; start = 1'b1;
            @(posedge clk); #1 start = 1'b0; sub = 1'b0;
            n = 0;
            while (done !== 1'b1 && n < 12) begin @(posedge clk); #1; n++; end
            checks++; if (sum !== vs[i]) begin errors++; $display("FAIL sub_sum[%0d] got %h want %h", i, sum, vs[i]); end
            checks++; if (carry_out !== vc[i]) begin errors++; $display("FAIL sub_cout[%0d] got %b want %b", i, carry_out, vc[i]); end
            @(posedge clk); #1;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_latency();
        test_add_vectors();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
`ifdef SERIAL_ADDER_SUB_EN
        test_sub();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_serial_adder

`default_nettype wire
